// File: rtl/aes_word_loader.sv
// Word-serial loader/unloader around the AES-128 core: gathers key+plaintext words, starts the core, streams ciphertext back.
// Optional AES_KEY_REUSE_EN: a block whose first word has in_kld=0 carries plaintext only and keeps the previous key.
module aes_word_loader #(
  parameter int unsigned CORE_LAT = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_kld,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_data,
  output logic         busy,
  output logic [127:0] core_ptxt,
  output logic [127:0] core_key,
  output logic         core_valid,
  input  logic [127:0] core_ctxt
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BLK_W  = 128;
  localparam int unsigned CNT_W  = 8;
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(CORE_LAT - 1);

  typedef enum logic [1:0] {LOAD, START, WAIT, OUT} state_t;

  state_t              r_state;
  logic [2:0]          r_widx;
  logic [1:0]          r_oidx;
  logic [CNT_W-1:0]    r_cnt;
  logic [BLK_W-1:0]    r_key;
  logic [BLK_W-1:0]    r_ptxt;
  logic [BLK_W-1:0]    r_buf;
  logic                r_in_ready;
  logic                r_out_valid;
  logic [WORD_W-1:0]   r_out_data;
  logic                r_busy;
  logic                r_core_valid;

  logic                w_accept;
  logic                w_key_skip;
  logic [1:0]          w_slot;
  logic [1:0]          w_next_oidx;

  assign w_accept    = in_valid & r_in_ready;
  assign w_slot      = ~r_widx[1:0];
  assign w_next_oidx = r_oidx + 2'd1;

`ifdef AES_KEY_REUSE_EN
  // A plaintext-only block jumps straight to the plaintext half of the word index.
  assign w_key_skip = (r_widx == 3'd0) && !in_kld;
`else
  logic w_unused_kld;
  assign w_unused_kld = in_kld;
  assign w_key_skip   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= LOAD;
      r_widx       <= 3'd0;
      r_oidx       <= 2'd0;
      r_cnt        <= '0;
      r_key        <= '0;
      r_ptxt       <= '0;
      r_buf        <= '0;
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_busy       <= 1'b0;
      r_core_valid <= 1'b0;
    end else begin
      case (r_state)
        LOAD: begin
          if (w_accept) begin
            if (w_key_skip) begin
              r_ptxt[BLK_W-1 -: WORD_W] <= in_data;
              r_widx                    <= 3'd5;
            end else begin
              if (!r_widx[2]) r_key[{w_slot, 5'd0} +: WORD_W]  <= in_data;
              else            r_ptxt[{w_slot, 5'd0} +: WORD_W] <= in_data;
              r_widx <= r_widx + 3'd1;
            end
            if (r_widx == 3'd7) begin
              r_state      <= START;
              r_in_ready   <= 1'b0;
              r_busy       <= 1'b1;
              r_core_valid <= 1'b1;
            end
          end
        end
        START: begin
          r_core_valid <= 1'b0;
          r_cnt        <= '0;
          r_state      <= WAIT;
        end
        WAIT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          // Ciphertext is final in this cycle; capture it and present word 0.
          if (r_cnt == LAT_LAST) begin
            r_buf       <= core_ctxt;
            r_out_data  <= core_ctxt[BLK_W-1 -: WORD_W];
            r_out_valid <= 1'b1;
            r_oidx      <= 2'd0;
            r_state     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            if (r_oidx == 2'd3) begin
              r_state     <= LOAD;
              r_out_valid <= 1'b0;
              r_in_ready  <= 1'b1;
              r_busy      <= 1'b0;
              r_oidx      <= 2'd0;
            end else begin
              r_oidx     <= w_next_oidx;
              r_out_data <= r_buf[{~w_next_oidx, 5'd0} +: WORD_W];
            end
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign busy       = r_busy;
  assign core_ptxt  = r_ptxt;
  assign core_key   = r_key;
  assign core_valid = r_core_valid;

endmodule

// File: tb/tb_aes_word_loader.sv
// Bench for aes_word_loader: stand-in AES core, block-level reference model, per-cycle output comparison.
module tb_aes_word_loader;

  localparam int unsigned LAT = 12;
`ifdef AES_KEY_REUSE_EN
  localparam bit KLD_EN = 1'b1;
`else
  localparam bit KLD_EN = 1'b0;
`endif

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] ALT_KEY  = 128'h00000010000000200000003000000040;
  localparam logic [127:0] ALT_PT   = 128'h00000001000000020000000300000004;
  localparam logic [127:0] ALT_CT   = 128'h00000013000000240000003100000042;

  logic         clk, rst, in_valid, in_ready, in_kld, out_valid, out_ready, busy, core_valid;
  logic [31:0]  in_data, out_data;
  logic [127:0] core_ptxt, core_key, core_ctxt;

  aes_word_loader #(.CORE_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_kld(in_kld), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .core_ptxt(core_ptxt), .core_key(core_key), .core_valid(core_valid),
    .core_ctxt(core_ctxt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Stand-in core: real FIPS answer for the FIPS vector, simple mix otherwise; garbage until latency elapses.
  function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] p);
    if (k == FIPS_KEY && p == FIPS_PT) return FIPS_CT;
    return k ^ {p[63:0], p[127:64]};
  endfunction

  int fc_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) fc_cnt <= 0;
    else if (core_valid) fc_cnt <= 1;
    else if (fc_cnt != 0 && fc_cnt < 1000) fc_cnt <= fc_cnt + 1;
  end
  assign core_ctxt = (fc_cnt >= int'(LAT)) ? core_fn(core_key, core_ptxt) : 128'hdeadbeef_badc0ffe_deadbeef_badc0ffe;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  logic [31:0]  m_key [4];
  logic [31:0]  m_pt  [4];
  logic [127:0] m_ctxt;
  bit   m_load = 1'b1, m_outing = 1'b0, m_short = 1'b0;
  int   m_cnt = 0, m_oidx = 0, m_start_cyc = -1, m_out_from = 0;
  int   m_last_acc_cyc = 0, m_last_hs_cyc = 0, m_gap = 0, m_done = 0;
  int   n_pulses = 0, ov_rise = 0;
  bit   prev_ov = 1'b0, exp_cv, exp_ov;
  logic [31:0] q_out[$];

  always @(negedge clk) begin
    if (rst) begin
      chk("rst in_ready", 128'(in_ready), 128'd1);
      chk("rst out_valid", 128'(out_valid), 128'd0);
      chk("rst out_data", 128'(out_data), 128'd0);
      chk("rst core_valid", 128'(core_valid), 128'd0);
      chk("rst busy", 128'(busy), 128'd0);
      chk("rst core_key", core_key, 128'd0);
      chk("rst core_ptxt", core_ptxt, 128'd0);
      for (int i = 0; i < 4; i++) begin m_key[i] = '0; m_pt[i] = '0; end
      m_load = 1'b1; m_outing = 1'b0; m_cnt = 0; m_oidx = 0; m_start_cyc = -1; prev_ov = 1'b0;
    end else begin
      exp_cv = (cyc == m_start_cyc);
      exp_ov = m_outing && (cyc >= m_out_from);
      chk("in_ready", 128'(in_ready), 128'(m_load));
      chk("busy", 128'(busy), 128'(!m_load));
      chk("core_valid", 128'(core_valid), 128'(exp_cv));
      chk("out_valid", 128'(out_valid), 128'(exp_ov));
      if (exp_ov) chk("out_data", 128'(out_data), 128'(m_ctxt[127-32*m_oidx -: 32]));
      chk("core_key", core_key, {m_key[0], m_key[1], m_key[2], m_key[3]});
      chk("core_ptxt", core_ptxt, {m_pt[0], m_pt[1], m_pt[2], m_pt[3]});
      if (core_valid) n_pulses++;
      if (out_valid && !prev_ov) ov_rise = cyc;
      prev_ov = out_valid;
      // Input side of the model is evaluated before the output side so a drain cycle cannot also accept.
      if (m_load && in_valid) begin
        if (m_cnt == 0) begin
          m_short = KLD_EN && !in_kld;
          m_gap   = cyc - m_last_hs_cyc;
        end
        if (m_short)        m_pt[m_cnt]      = in_data;
        else if (m_cnt < 4) m_key[m_cnt]     = in_data;
        else                m_pt[m_cnt - 4]  = in_data;
        m_cnt++;
        if (m_cnt == (m_short ? 4 : 8)) begin
          m_load = 1'b0; m_cnt = 0; m_outing = 1'b1; m_oidx = 0;
          m_start_cyc = cyc + 1; m_out_from = cyc + 2 + int'(LAT); m_last_acc_cyc = cyc;
          m_ctxt = core_fn({m_key[0], m_key[1], m_key[2], m_key[3]}, {m_pt[0], m_pt[1], m_pt[2], m_pt[3]});
        end
      end
      if (exp_ov && out_ready) begin
        q_out.push_back(out_data);
        m_oidx++;
        if (m_oidx == 4) begin
          m_outing = 1'b0; m_load = 1'b1; m_oidx = 0; m_done++; m_last_hs_cyc = cyc;
        end
      end
    end
  end

  task automatic send_word(input logic [31:0] d, input logic kld, input int gap);
    int w;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1; in_data = d; in_kld = kld;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 400) begin w++; @(negedge clk); end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL send_word timeout: in_ready stayed %b for word %h", in_ready, d);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_kld = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] k, input logic [127:0] p, input bit with_key,
                            input logic kld, input bit rnd);
    bit first = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (with_key || i >= 4) begin
        send_word(i < 4 ? k[127-32*i -: 32] : p[127-32*(i-4) -: 32], first ? kld : 1'b0,
                  rnd ? int'($urandom_range(0, 2)) : 0);
        first = 1'b0;
      end
    end
  endtask

  task automatic wait_done(input int n);
    int w = 0;
    while (m_done < n && w < 2000) begin @(negedge clk); w++; end
    if (m_done < n) begin
      n_checks++; n_fail++;
      $display("FAIL wait_done timeout: blocks done %0d expected %0d", m_done, n);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_out(input string nm, input logic [127:0] exp);
    chk({nm, " word count"}, 128'(q_out.size()), 128'd4);
    for (int i = 0; i < 4; i++)
      if (i < q_out.size()) chk($sformatf("%s word%0d", nm, i), 128'(q_out[i]), 128'(exp[127-32*i -: 32]));
    q_out.delete();
  endtask

  initial begin
    int w;
    logic kb;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_kld = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // FIPS vector, no stalls
    n_pulses = 0;
    send_block(FIPS_KEY, FIPS_PT, 1'b1, 1'b1, 1'b0);
    wait_done(1);
    check_out("fips", FIPS_CT);
    chk("fips latency", 128'(ov_rise - m_last_acc_cyc), 128'(LAT + 2));
    chk("fips pulses", 128'(n_pulses), 128'd1);

    // Random input gaps plus a 5-cycle output stall
    n_pulses = 0;
    out_ready = 1'b0;
    send_block(FIPS_KEY, FIPS_PT, 1'b1, 1'b1, 1'b1);
    w = 0;
    @(negedge clk);
    while (!out_valid && w < 200) begin w++; @(negedge clk); end
    chk("bp out_valid seen", 128'(out_valid), 128'd1);
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_done(2);
    check_out("bp", FIPS_CT);
    chk("bp latency", 128'(ov_rise - m_last_acc_cyc), 128'(LAT + 2));
    chk("bp pulses", 128'(n_pulses), 128'd1);

    // Next block held on the input throughout WAIT/OUT
    n_pulses = 0;
    kb = KLD_EN;
    send_block(FIPS_KEY, FIPS_PT, 1'b1, 1'b1, 1'b0);
    send_block(ALT_KEY, ALT_PT, 1'b1, kb, 1'b0);
    chk("blocked first accept gap", 128'(m_gap), 128'd1);
    wait_done(4);
    chk("blocked words", 128'(q_out.size()), 128'd8);
    if (q_out.size() >= 8) begin
      chk("blocked A word0", 128'(q_out[0]), 128'h69c4e0d8);
      chk("blocked A word3", 128'(q_out[3]), 128'h70b4c55a);
      chk("blocked B word0", 128'(q_out[4]), 128'h00000013);
      chk("blocked B word1", 128'(q_out[5]), 128'h00000024);
      chk("blocked B word2", 128'(q_out[6]), 128'h00000031);
      chk("blocked B word3", 128'(q_out[7]), 128'h00000042);
    end
    q_out.delete();
    chk("blocked pulses", 128'(n_pulses), 128'd2);

    // Reset after the 5th word, then the full vector
    for (int i = 0; i < 5; i++)
      send_word(i < 4 ? FIPS_KEY[127-32*i -: 32] : FIPS_PT[127 -: 32], i == 0 ? 1'b1 : 1'b0, 0);
    rst = 1'b1;
    #1;
    chk("midrst in_ready", 128'(in_ready), 128'd1);
    chk("midrst busy", 128'(busy), 128'd0);
    chk("midrst core_key", core_key, 128'd0);
    chk("midrst core_ptxt", core_ptxt, 128'd0);
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b0;
    n_pulses = 0;
    send_block(FIPS_KEY, FIPS_PT, 1'b1, 1'b1, 1'b0);
    wait_done(5);
    check_out("after rst", FIPS_CT);
    chk("after rst pulses", 128'(n_pulses), 128'd1);

`ifdef AES_KEY_REUSE_EN
    // Full block then a plaintext-only block reusing the key
    n_pulses = 0;
    send_block(FIPS_KEY, FIPS_PT, 1'b1, 1'b1, 1'b0);
    wait_done(6);
    check_out("kr block1", FIPS_CT);
    send_block(FIPS_KEY, FIPS_PT, 1'b0, 1'b0, 1'b0);
    wait_done(7);
    check_out("kr block2", FIPS_CT);
    chk("kr key kept", core_key, FIPS_KEY);
    chk("kr pulses", 128'(n_pulses), 128'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
